// File: rtl/servant_wb_loader_pkg.sv
// Shared types and constants for the servant Wishbone RAM loader.
package servant_wb_loader_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    WRITE,
    VERIFY,
    FULL,
    DONE
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'h0;
  localparam logic [3:0] SEL_ALL  = 4'hf;

  // Expand a 4-bit byte-lane select into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/servant_byte_packer.sv
// Packs a byte stream little-endian into a 32-bit word with per-lane select and last flag.
module servant_byte_packer
  import servant_wb_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  input  logic        clear_i,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        word_rdy_o,
  output logic        last_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        last_q, last_d;
  logic [3:0]  lane;

  assign lane = 4'b0001 << idx_q;

  always_comb begin
    idx_d  = idx_q;
    dat_d  = dat_q;
    sel_d  = sel_q;
    last_d = last_q;
    if (clear_i) begin
      idx_d  = 2'd0;
      dat_d  = 32'h0;
      sel_d  = SEL_NONE;
      last_d = 1'b0;
    end else if (accept_i) begin
      dat_d[{idx_q, 3'b000} +: 8] = data_i;
      sel_d  = sel_q | lane;
      idx_d  = idx_q + 2'd1;
      last_d = last_i;
    end
  end

  // Word is ready when this byte fills the final lane or ends the image.
  assign word_rdy_o = accept_i && (((sel_q | lane) == SEL_ALL) || last_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= 2'd0;
      dat_q  <= 32'h0;
      sel_q  <= SEL_NONE;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      dat_q  <= dat_d;
      sel_q  <= sel_d;
      last_q <= last_d;
    end
  end

  assign dat_o  = dat_q;
  assign sel_o  = sel_q;
  assign last_o = last_q;

endmodule

// File: rtl/servant_wb_loader.sv
// Wishbone initiator filling servant RAM from a byte stream; holds the CPU in reset until loaded.
// Define SERVANT_LOADER_VERIFY_EN to read back and compare every written word.
module servant_wb_loader
  import servant_wb_loader_pkg::*;
#(
  parameter int unsigned depth = 256,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  input  logic          i_last,
  output logic          o_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_done,
  output logic          o_overflow,
  output logic          o_err,
  output logic          o_cpu_rst
);

  localparam int unsigned AdrW  = aw - 2;
  localparam int unsigned Words = depth / 4;
  localparam logic [AdrW-1:0] LastAdr = AdrW'(Words - 1);

  state_t          state_q, state_d;
  logic [AdrW-1:0] adr_q, adr_d;
  logic            overflow_q, overflow_d;
  logic            err_q, err_d;
  logic            accept, pack_accept, advance;
  logic            word_rdy, pack_last;
  logic [31:0]     pack_dat;
  logic [3:0]      pack_sel;

  assign o_ready     = (state_q == COLLECT) || (state_q == FULL) || (state_q == DONE);
  assign accept      = i_valid && o_ready;
  assign pack_accept = accept && (state_q == COLLECT);

  servant_byte_packer u_packer (
    .clk_i      (i_wb_clk),
    .rst_i      (i_wb_rst),
    .accept_i   (pack_accept),
    .data_i     (i_data),
    .last_i     (i_last),
    .clear_i    (advance),
    .dat_o      (pack_dat),
    .sel_o      (pack_sel),
    .word_rdy_o (word_rdy),
    .last_o     (pack_last)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    advance    = 1'b0;
    unique case (state_q)
      COLLECT: if (word_rdy) state_d = WRITE;
      WRITE: begin
        if (i_wb_ack) begin
`ifdef SERVANT_LOADER_VERIFY_EN
          state_d = VERIFY;
`else
          advance = 1'b1;
`endif
        end
      end
      VERIFY: begin
`ifdef SERVANT_LOADER_VERIFY_EN
        if (i_wb_ack) begin
          if (((i_wb_rdt ^ pack_dat) & lane_mask(pack_sel)) != 32'h0) err_d = 1'b1;
          advance = 1'b1;
        end
`else
        state_d = COLLECT;
`endif
      end
      FULL: begin
        if (accept) begin
          overflow_d = 1'b1;
          if (i_last) state_d = DONE;
        end
      end
      DONE: if (accept) overflow_d = 1'b1;
      default: state_d = COLLECT;
    endcase
    // Word retired: the address saturates at the top of RAM instead of wrapping.
    if (advance) begin
      if (pack_last)             state_d = DONE;
      else if (adr_q == LastAdr) state_d = FULL;
      else                       state_d = COLLECT;
      if (adr_q != LastAdr) adr_d = adr_q + AdrW'(1);
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q    <= COLLECT;
      adr_q      <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

`ifndef SERVANT_LOADER_VERIFY_EN
  logic unused_rdt;
  assign unused_rdt = ^i_wb_rdt;
`endif

  assign o_wb_cyc   = (state_q == WRITE) || (state_q == VERIFY);
  assign o_wb_we    = (state_q == WRITE);
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = pack_dat;
  assign o_wb_sel   = pack_sel;
  assign o_done     = (state_q == DONE);
  assign o_cpu_rst  = !o_done;
  assign o_overflow = overflow_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_servant_wb_loader.sv
// Scoreboard bench for servant_wb_loader with a 64-word RAM model acking one cycle after cyc.
module tb_servant_wb_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [5:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic [5:0]  o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        ack = 1'b0;
  logic        o_done, o_overflow, o_err, o_cpu_rst;
  logic        corrupt = 1'b0;
  bit          expect_idle = 1'b0;

  logic [31:0] ram[64];
  logic [31:0] exp_ram[64];
  wr_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  initial forever #5 clk = ~clk;

  servant_wb_loader #(.depth(256)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (ack),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_err      (o_err),
    .o_cpu_rst  (o_cpu_rst)
  );

  assign i_wb_rdt = ram[o_wb_adr] ^ ((corrupt && o_wb_adr == 6'd3) ? 32'h00FF_0000 : 32'h0);

  function automatic logic [31:0] mask_of(input logic [3:0] sel);
    logic [31:0] m = 32'h0;
    for (int k = 0; k < 4; k++) if (sel[k]) m[8*k +: 8] = 8'hff;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM target: writes enabled lanes on the edge that completes the cycle.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) ack <= 1'b0;
    else begin
      if (o_wb_cyc && o_wb_we && ack)
        for (int k = 0; k < 4; k++)
          if (o_wb_sel[k]) ram[o_wb_adr][8*k +: 8] = o_wb_dat[8*k +: 8];
      ack <= o_wb_cyc && !ack;
    end
  end

  // Monitor: every completed write is popped against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_wb_cyc && o_wb_we && ack) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got adr %0d dat %h sel %b, expected no write",
                   o_wb_adr, o_wb_dat, o_wb_sel);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wb_write", {22'h0, o_wb_adr, o_wb_dat, o_wb_sel}, {22'h0, e});
        end
      end
      if (expect_idle) check("idle_no_cyc", o_wb_cyc, 1'b0);
    end
  end

  // Reference: image bytes become consecutive words from 0; a partial word only with last.
  task automatic model(input byte_q_t b, input bit has_last);
    int n = b.size();
    for (int w = 0; w < 64 && 4 * w < n; w++) begin
      int cnt;
      wr_t e;
      logic [31:0] m;
      cnt = (n - 4 * w >= 4) ? 4 : n - 4 * w;
      if (cnt < 4 && !has_last) break;
      e.adr = 6'(w);
      e.dat = 32'h0;
      e.sel = 4'h0;
      for (int k = 0; k < cnt; k++) begin
        e.dat[8*k +: 8] = b[4*w + k];
        e.sel[k] = 1'b1;
      end
      m = mask_of(e.sel);
      exp_ram[w] = (exp_ram[w] & ~m) | (e.dat & m);
      exp_q.push_back(e);
    end
  endtask

  // Entered just after a rising edge; returns just after the accepting edge with valid held.
  task automatic send(input logic [7:0] b, input logic l);
    int n = 0;
    i_valid = 1'b1;
    i_data  = b;
    i_last  = l;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) check("ready_timeout", o_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic run_image(input byte_q_t b, input bit has_last);
    model(b, has_last);
    for (int i = 0; i < b.size(); i++) send(b[i], has_last && (i == b.size() - 1));
    idle();
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done && exp_q.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check({name, "_done"}, o_done, 1'b1);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int i = 63; i >= 0; i--) if (ram[i] !== exp_ram[i]) bad = i;
    check(name, ram[bad], exp_ram[bad]);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    exp_q.delete();
    expect_idle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte_q_t b;
    logic [31:0] pre;
    for (int i = 0; i < 64; i++) begin
      ram[i]     = $urandom;
      exp_ram[i] = ram[i];
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_bus", {o_wb_cyc, o_wb_we, o_wb_sel, o_wb_adr}, 0);
    check("rst_dat", o_wb_dat, 32'h0);
    check("rst_flags", {o_done, o_overflow, o_err, o_cpu_rst}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two full words.
    b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_image(b, 1'b1);
    wait_done("eight");
    check("eight_adr0", ram[0], 32'h04030201);
    check("eight_adr1", ram[1], 32'h08070605);
    check("eight_flags", {o_cpu_rst, o_overflow, o_err}, 3'b000);

    // Partial final word keeps untouched lanes.
    do_reset();
    pre = ram[1];
    b = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_image(b, 1'b1);
    wait_done("six");
    check("six_adr0", ram[0], 32'hDDCCBBAA);
    check("six_adr1", ram[1], {pre[31:16], 16'hFFEE});
    check_ram("six_ram");

    // Random short images.
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 40);
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      run_image(b, 1'b1);
      wait_done("rand");
      check_ram("rand_ram");
      check("rand_flags", {o_overflow, o_err, o_cpu_rst}, 3'b000);
    end

    // 260 bytes with valid held: 64 writes, overflow from byte 257.
    do_reset();
    b.delete();
    for (int i = 0; i < 260; i++) b.push_back(8'($urandom));
    model(b, 1'b1);
    for (int i = 0; i < 256; i++) send(b[i], 1'b0);
    check("full_no_ovf", o_overflow, 1'b0);
    send(b[256], 1'b0);
    expect_idle = 1'b1;
    check("full_ovf", o_overflow, 1'b1);
    check("full_not_done", o_done, 1'b0);
    send(b[257], 1'b0);
    send(b[258], 1'b0);
    send(b[259], 1'b1);
    idle();
    wait_done("full");
    check("full_ovf_end", o_overflow, 1'b1);
    check_ram("full_ram");

    // Reset while writing word 5.
    do_reset();
    b.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    run_image(b, 1'b0);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
    idle();
    check("mid_cyc_adr5", {o_wb_cyc, o_wb_adr}, {1'b1, 6'd5});
    check("mid_sb_empty", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check("mid_async_drop", {o_wb_cyc, o_done, o_cpu_rst}, 3'b001);
    do_reset();
    b = {8'h11, 8'h22, 8'h33, 8'h44};
    run_image(b, 1'b1);
    wait_done("restart");
    check("restart_adr0", ram[0], 32'h44332211);
    check_ram("restart_ram");

    // Bytes after done are discarded.
    expect_idle = 1'b1;
    check("post_ovf_before", o_overflow, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("post_ready", o_ready, 1'b1);
      send(8'($urandom), 1'b0);
    end
    idle();
    @(posedge clk);
    #1;
    check("post_flags", {o_overflow, o_done, o_cpu_rst}, 3'b110);
    check_ram("post_ram");
    expect_idle = 1'b0;

`ifdef SERVANT_LOADER_VERIFY_EN
    // Readback corruption on lane 2 of word 3.
    do_reset();
    corrupt = 1'b1;
    b.delete();
    for (int i = 0; i < 24; i++) b.push_back(8'($urandom));
    model(b, 1'b1);
    for (int i = 0; i < 12; i++) send(b[i], 1'b0);
    check("verify_err_early", o_err, 1'b0);
    for (int i = 12; i < 24; i++) send(b[i], i == 23);
    idle();
    wait_done("verify");
    check("verify_err", o_err, 1'b1);
    check_ram("verify_ram");
    corrupt = 1'b0;
`else
    check("err_tied", o_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
